wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 139 +++++++++++++
 tb/tb_wb_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline latch, 32x32 register file with
// writeback bypass on both read ports, and a retired-instruction counter.
module wb_stage (
    input  logic        clk,
    input  logic        clrn,
    input  logic        m_valid,
    input  logic        m_wreg,
    input  logic        m_m2reg,
    input  logic [4:0]  m_rd,
    input  logic [31:0] m_alu,
    input  logic [31:0] m_mem,
    input  logic        stall,
    input  logic        flush,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic [31:0] qa,
    output logic [31:0] qb,
    output logic [4:0]  w_rd,
    output logic        w_wreg,
    output logic [31:0] w_data,
    output logic [31:0] retired
);

    logic        valid_r;
    logic        wreg_r;
    logic        m2reg_r;
    logic [4:0]  rd_r;
    logic [31:0] alu_r;
    logic [31:0] mem_r;
    logic [31:0] regs_r [32];
    logic [31:0] retired_r;

    logic        advance_s;
    logic        w_wreg_s;
    logic        reg_we_s;
    logic [31:0] w_data_s;
    logic [31:0] qa_s;
    logic [31:0] qb_s;

    // Edge qualification and writeback data selection.
    always_comb begin
        advance_s = ~stall | flush;
        w_wreg_s  = valid_r & wreg_r;
        w_data_s  = m2reg_r ? mem_r : alu_r;
        // A stalled instruction is written only on the edge that finally moves it out.
        reg_we_s  = advance_s & w_wreg_s & (rd_r != 5'd0);
    end

    // MEM/WB latch: load, bubble on flush (flush beats stall), or hold.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid_r <= 1'b0;
            wreg_r  <= 1'b0;
            m2reg_r <= 1'b0;
            rd_r    <= 5'd0;
            alu_r   <= 32'd0;
            mem_r   <= 32'd0;
        end else if (advance_s) begin
            if (flush) begin
                valid_r <= 1'b0;
                wreg_r  <= 1'b0;
                m2reg_r <= 1'b0;
                rd_r    <= 5'd0;
                alu_r   <= 32'd0;
                mem_r   <= 32'd0;
            end else begin
                valid_r <= m_valid;
                wreg_r  <= m_wreg;
                m2reg_r <= m_m2reg;
                rd_r    <= m_rd;
                alu_r   <= m_alu;
                mem_r   <= m_mem;
            end
        end else begin
            valid_r <= valid_r;
            wreg_r  <= wreg_r;
            m2reg_r <= m2reg_r;
            rd_r    <= rd_r;
            alu_r   <= alu_r;
            mem_r   <= mem_r;
        end
    end

    // Register file; entry 0 is never written so it reads as zero.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (reg_we_s) begin
            regs_r[rd_r] <= w_data_s;
        end else begin
            regs_r[rd_r] <= regs_r[rd_r];
        end
    end

    // Retired counter: counts valid instructions leaving the latch, wraps naturally.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            retired_r <= 32'd0;
        end else if (advance_s && valid_r) begin
            retired_r <= retired_r + 32'd1;
        end else begin
            retired_r <= retired_r;
        end
    end

    // Read port A with bypass from the latched writeback value.
    always_comb begin
        qa_s = 32'd0;
        if (rs == 5'd0) begin
            qa_s = 32'd0;
        end else if (w_wreg_s && (rd_r == rs)) begin
            qa_s = w_data_s;
        end else begin
            qa_s = regs_r[rs];
        end
    end

    // Read port B with bypass from the latched writeback value.
    always_comb begin
        qb_s = 32'd0;
        if (rt == 5'd0) begin
            qb_s = 32'd0;
        end else if (w_wreg_s && (rd_r == rt)) begin
            qb_s = w_data_s;
        end else begin
            qb_s = regs_r[rt];
        end
    end

    assign qa      = qa_s;
    assign qb      = qb_s;
    assign w_rd    = rd_r;
    assign w_wreg  = w_wreg_s;
    assign w_data  = w_data_s;
    assign retired = retired_r;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized
// traffic compared against an architectural model of the writeback stage.
module tb_wb_stage;

    logic        clk;
    logic        clrn;
    logic        m_valid, m_wreg, m_m2reg;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_mem;
    logic        stall, flush;
    logic [4:0]  rs, rt;
    logic [31:0] qa, qb;
    logic [4:0]  w_rd;
    logic        w_wreg;
    logic [31:0] w_data;
    logic [31:0] retired;

    int n_cmp = 0;
    int n_err = 0;

    // Architectural model: the instruction waiting to retire, the register array, retire count.
    logic        mv, mw, mm2;
    logic [4:0]  mrd;
    logic [31:0] malu, mmem, mret;
    logic [31:0] mregs [32];

    wb_stage dut (
        .clk(clk), .clrn(clrn),
        .m_valid(m_valid), .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_rd(m_rd),
        .m_alu(m_alu), .m_mem(m_mem), .stall(stall), .flush(flush),
        .rs(rs), .rt(rt), .qa(qa), .qb(qb),
        .w_rd(w_rd), .w_wreg(w_wreg), .w_data(w_data), .retired(retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] exp_wdata();
        return mm2 ? mmem : malu;
    endfunction

    function automatic logic exp_wwreg();
        return mv && mw;
    endfunction

    function automatic logic [31:0] exp_q(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (exp_wwreg() && mrd == a) return exp_wdata();
        return mregs[a];
    endfunction

    task automatic model_reset();
        mv = 1'b0; mw = 1'b0; mm2 = 1'b0; mrd = 5'd0;
        malu = 32'd0; mmem = 32'd0; mret = 32'd0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    endtask

    task automatic model_edge();
        if (!stall || flush) begin
            if (mv && mw && mrd != 5'd0) mregs[mrd] = exp_wdata();
            if (mv) mret = mret + 32'd1;
            if (flush) begin
                mv = 1'b0; mw = 1'b0; mm2 = 1'b0; mrd = 5'd0; malu = 32'd0; mmem = 32'd0;
            end else begin
                mv = m_valid; mw = m_wreg; mm2 = m_m2reg; mrd = m_rd; malu = m_alu; mmem = m_mem;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic m2, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic st, input logic fl);
        m_valid = v; m_wreg = w; m_m2reg = m2; m_rd = rd;
        m_alu = alu; m_mem = mem; stall = st; flush = fl;
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rs = 5'd5; rt = 5'd7;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (w_rd !== 5'd0) begin n_err++; $display("FAIL reset_w_rd: got %h want 0", w_rd); end
        n_cmp++; if (w_wreg !== 1'b0) begin n_err++; $display("FAIL reset_w_wreg: got %b want 0", w_wreg); end
        n_cmp++; if (w_data !== 32'd0) begin n_err++; $display("FAIL reset_w_data: got %h want 0", w_data); end
        n_cmp++; if (qa !== 32'd0) begin n_err++; $display("FAIL reset_qa: got %h want 0", qa); end
        n_cmp++; if (qb !== 32'd0) begin n_err++; $display("FAIL reset_qb: got %h want 0", qb); end
        n_cmp++; if (retired !== 32'd0) begin n_err++; $display("FAIL reset_retired: got %h want 0", retired); end
        clrn = 1'b1;
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h0000DEAD, 32'h00000005, 1'b0, 1'b0);
        rs = 5'd3; rt = 5'd0;
        tick();
        n_cmp++; if (w_data !== 32'h5) begin n_err++; $display("FAIL basic_w_data: got %h want 5", w_data); end
        n_cmp++; if (w_wreg !== 1'b1) begin n_err++; $display("FAIL basic_w_wreg: got %b want 1", w_wreg); end
        n_cmp++; if (w_rd !== 5'd3) begin n_err++; $display("FAIL basic_w_rd: got %h want 3", w_rd); end
        n_cmp++; if (qa !== 32'h5) begin n_err++; $display("FAIL basic_bypass_qa: got %h want 5", qa); end
        n_cmp++; if (dut.regs_r[3] !== 32'h0) begin n_err++; $display("FAIL basic_early_write: got %h want 0", dut.regs_r[3]); end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (dut.regs_r[3] !== 32'h5) begin n_err++; $display("FAIL basic_regfile: got %h want 5", dut.regs_r[3]); end
        n_cmp++; if (qa !== 32'h5) begin n_err++; $display("FAIL basic_read_qa: got %h want 5", qa); end
        n_cmp++; if (retired !== 32'd1) begin n_err++; $display("FAIL basic_retired: got %h want 1", retired); end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h8, 32'h0000BEEF, 1'b0, 1'b0);
        rs = 5'd4;
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h55, 32'h0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (qa !== 32'h8) begin n_err++; $display("FAIL stall_bypass_qa: got %h want 8", qa); end
            n_cmp++; if (dut.regs_r[4] !== 32'h0) begin n_err++; $display("FAIL stall_no_write: got %h want 0", dut.regs_r[4]); end
            n_cmp++; if (retired !== 32'd1) begin n_err++; $display("FAIL stall_retired: got %h want 1", retired); end
            n_cmp++; if (w_rd !== 5'd4) begin n_err++; $display("FAIL stall_hold_rd: got %h want 4", w_rd); end
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (dut.regs_r[4] !== 32'h8) begin n_err++; $display("FAIL stall_release_write: got %h want 8", dut.regs_r[4]); end
        n_cmp++; if (retired !== 32'd2) begin n_err++; $display("FAIL stall_release_retired: got %h want 2", retired); end
        n_cmp++; if (dut.regs_r[5] !== 32'h0) begin n_err++; $display("FAIL stall_dropped_rd5: got %h want 0", dut.regs_r[5]); end
        tick();
        n_cmp++; if (retired !== 32'd2) begin n_err++; $display("FAIL stall_once_retired: got %h want 2", retired); end
    endtask

    task automatic test_flush_stall();
        drive(1'b1, 1'b1, 1'b0, 5'd6, 32'h77, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h1, 32'h2, 1'b1, 1'b1);
        tick();
        n_cmp++; if (w_wreg !== 1'b0) begin n_err++; $display("FAIL flush_w_wreg: got %b want 0", w_wreg); end
        n_cmp++; if (w_data !== 32'd0) begin n_err++; $display("FAIL flush_w_data: got %h want 0", w_data); end
        n_cmp++; if (w_rd !== 5'd0) begin n_err++; $display("FAIL flush_w_rd: got %h want 0", w_rd); end
        n_cmp++; if (dut.regs_r[6] !== 32'h77) begin n_err++; $display("FAIL flush_prev_write: got %h want 77", dut.regs_r[6]); end
        n_cmp++; if (dut.regs_r[7] !== 32'h0) begin n_err++; $display("FAIL flush_rd7: got %h want 0", dut.regs_r[7]); end
        n_cmp++; if (retired !== 32'd3) begin n_err++; $display("FAIL flush_retired: got %h want 3", retired); end
        tick();
        n_cmp++; if (retired !== 32'd3) begin n_err++; $display("FAIL flush_retired_once: got %h want 3", retired); end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_r0_wrap();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
        rs = 5'd0;
        tick();
        n_cmp++; if (w_data !== 32'hFFFFFFFF) begin n_err++; $display("FAIL r0_w_data: got %h want ffffffff", w_data); end
        n_cmp++; if (qa !== 32'd0) begin n_err++; $display("FAIL r0_qa: got %h want 0", qa); end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (dut.regs_r[0] !== 32'd0) begin n_err++; $display("FAIL r0_regfile: got %h want 0", dut.regs_r[0]); end
        n_cmp++; if (retired !== 32'd4) begin n_err++; $display("FAIL r0_retired: got %h want 4", retired); end
        force dut.retired_r = 32'hFFFFFFFF;
        #1;
        release dut.retired_r;
        mret = 32'hFFFFFFFF;
        n_cmp++; if (retired !== 32'hFFFFFFFF) begin n_err++; $display("FAIL wrap_preload: got %h want ffffffff", retired); end
        drive(1'b1, 1'b0, 1'b0, 5'd9, 32'h3, 32'h0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (retired !== 32'hFFFFFFFF) begin n_err++; $display("FAIL wrap_hold: got %h want ffffffff", retired); end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (retired !== 32'd0) begin n_err++; $display("FAIL wrap_zero: got %h want 0", retired); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom, $urandom,
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
            tick();
            rs = ($urandom_range(0, 2) == 0) ? mrd : 5'($urandom_range(0, 7));
            rt = ($urandom_range(0, 2) == 0) ? mrd : 5'($urandom_range(0, 7));
            #1;
            n_cmp++; if (w_data !== exp_wdata()) begin n_err++; $display("FAIL rand_w_data c=%0d: got %h want %h", c, w_data, exp_wdata()); end
            n_cmp++; if (w_wreg !== exp_wwreg()) begin n_err++; $display("FAIL rand_w_wreg c=%0d: got %b want %b", c, w_wreg, exp_wwreg()); end
            n_cmp++; if (w_rd !== mrd) begin n_err++; $display("FAIL rand_w_rd c=%0d: got %h want %h", c, w_rd, mrd); end
            n_cmp++; if (qa !== exp_q(rs)) begin n_err++; $display("FAIL rand_qa c=%0d rs=%0d: got %h want %h", c, rs, qa, exp_q(rs)); end
            n_cmp++; if (qb !== exp_q(rt)) begin n_err++; $display("FAIL rand_qb c=%0d rt=%0d: got %h want %h", c, rt, qb, exp_q(rt)); end
            n_cmp++; if (retired !== mret) begin n_err++; $display("FAIL rand_retired c=%0d: got %h want %h", c, retired, mret); end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h1234, 32'h0, 1'b0, 1'b0);
        rs = 5'd9; rt = 5'd0;
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        #2;
        clrn = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (w_rd !== 5'd0) begin n_err++; $display("FAIL areset_w_rd: got %h want 0", w_rd); end
        n_cmp++; if (w_wreg !== 1'b0) begin n_err++; $display("FAIL areset_w_wreg: got %b want 0", w_wreg); end
        n_cmp++; if (w_data !== 32'd0) begin n_err++; $display("FAIL areset_w_data: got %h want 0", w_data); end
        n_cmp++; if (qa !== 32'd0) begin n_err++; $display("FAIL areset_qa: got %h want 0", qa); end
        n_cmp++; if (retired !== 32'd0) begin n_err++; $display("FAIL areset_retired: got %h want 0", retired); end
        stall = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (dut.regs_r[9] !== 32'd0) begin n_err++; $display("FAIL areset_no_write: got %h want 0", dut.regs_r[9]); end
        clrn = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 5'd10, 32'h0, 32'h0000CAFE, 1'b0, 1'b0);
        rs = 5'd10;
        tick();
        n_cmp++; if (w_data !== 32'hCAFE) begin n_err++; $display("FAIL areset_first_edge: got %h want cafe", w_data); end
        n_cmp++; if (qa !== 32'hCAFE) begin n_err++; $display("FAIL areset_first_bypass: got %h want cafe", qa); end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (dut.regs_r[10] !== 32'hCAFE) begin n_err++; $display("FAIL areset_post_write: got %h want cafe", dut.regs_r[10]); end
        n_cmp++; if (retired !== 32'd1) begin n_err++; $display("FAIL areset_post_retired: got %h want 1", retired); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_flush_stall();
        test_r0_wrap();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
